// File: rtl/life_gen_ctrl.sv
// Purpose: generation sequencer for a life_col4 column array (pattern load, run/step enable pulses, status flags).
// Latency: write strobe one clock after load accept; enable pulse spacing max(gen_period,1)+2 clocks in RUN.
// Backpressure: load_ready is high only in IDLE; writes are accepted on load_valid & load_ready.
//
// Optional feature: define LIFE_CTRL_AUTO_HALT_EN to halt a free run on a stable board.
// Without it, stability is only flagged and the run continues until extinct or cmd_stop.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   load_valid/load_ready           pattern-write handshake; load_col_idx, load_val = target column, data
//   cmd_run, cmd_step, cmd_stop     control pulses
//   gen_period                      clocks between enable pulses in RUN (0 behaves as 1)
//   col_write_enb, col_val          one-hot column write strobe and shared write data
//   col_enable                      array-wide one-cycle generation enable
//   alive_flat, alive_prev_flat     flattened current / previous cell state from the columns
//   busy, halted, gen_count         status
//   extinct, stable, load_err       sticky flags
module life_gen_ctrl #(
    parameter int NUM_COLS = 4,
    parameter int ROWS     = 4,
    parameter int DIV_W    = 16,
    localparam int IDX_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [IDX_W-1:0]         load_col_idx,
    input  logic [ROWS-1:0]          load_val,
    input  logic                     cmd_run,
    input  logic                     cmd_step,
    input  logic                     cmd_stop,
    input  logic [DIV_W-1:0]         gen_period,
    output logic [NUM_COLS-1:0]      col_write_enb,
    output logic [ROWS-1:0]          col_val,
    output logic                     col_enable,
    input  logic [NUM_COLS*ROWS-1:0] alive_flat,
    input  logic [NUM_COLS*ROWS-1:0] alive_prev_flat,
    output logic                     busy,
    output logic                     halted,
    output logic [15:0]              gen_count,
    output logic                     extinct,
    output logic                     stable,
    output logic                     load_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RUN_WAIT = 3'd2,
        TICK     = 3'd3,
        SETTLE   = 3'd4,
        HALT     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic                  run_mode_q, run_mode_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [NUM_COLS-1:0]   col_write_enb_q, col_write_enb_d;
    logic [ROWS-1:0]       col_val_q, col_val_d;
    logic                  col_enable_q, col_enable_d;
    logic [15:0]           gen_count_q, gen_count_d;
    logic                  extinct_q, extinct_d;
    logic                  stable_q, stable_d;
    logic                  load_err_q, load_err_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;
    logic                  load_ready_q, load_ready_d;

    // One-hot decode of the write index; an all-zero result marks an out-of-range index.
    logic [NUM_COLS-1:0]   col_sel;
    logic                  idx_in_range;
    always_comb begin
        col_sel = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (load_col_idx == IDX_W'(c)) begin
                col_sel[c] = 1'b1;
            end
        end
        idx_in_range = |col_sel;
    end

    // A period of zero behaves like one, so the wait phase always lasts at least one clock.
    logic [DIV_W-1:0] reload_val;
    assign reload_val = (gen_period == '0) ? '0 : gen_period - DIV_W'(1);

    logic board_dead, board_same;
    assign board_dead = (alive_flat == '0);
    assign board_same = (alive_flat == alive_prev_flat);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        run_mode_d      = run_mode_q;
        stop_pend_d     = stop_pend_q;
        col_write_enb_d = '0;
        col_val_d       = '0;
        col_enable_d    = 1'b0;
        gen_count_d     = gen_count_q;
        extinct_d       = extinct_q;
        stable_d        = stable_q;
        load_err_d      = load_err_q;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (load_valid) begin
                    state_d         = WRITE;
                    col_write_enb_d = col_sel;
                    col_val_d       = load_val;
                    gen_count_d     = '0;
                    if (!idx_in_range) begin
                        load_err_d = 1'b1;
                    end
                end else if (cmd_run) begin
                    extinct_d  = 1'b0;
                    stable_d   = 1'b0;
                    run_mode_d = 1'b1;
                    cnt_d      = reload_val;
                    state_d    = RUN_WAIT;
                end else if (cmd_step) begin
                    extinct_d    = 1'b0;
                    stable_d     = 1'b0;
                    run_mode_d   = 1'b0;
                    state_d      = TICK;
                    col_enable_d = 1'b1;
                    gen_count_d  = gen_count_q + 16'd1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            RUN_WAIT: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d      = TICK;
                    col_enable_d = 1'b1;
                    gen_count_d  = gen_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            TICK: begin
                // The pulse is already out; a stop here only changes where SETTLE goes.
                stop_pend_d = stop_pend_q | cmd_stop;
                state_d     = SETTLE;
            end
            SETTLE: begin
                extinct_d   = board_dead;
                stable_d    = board_same;
                stop_pend_d = 1'b0;
                if (!run_mode_q || stop_pend_q || cmd_stop) begin
                    state_d = IDLE;
                end else if (board_dead) begin
                    state_d = HALT;
`ifdef LIFE_CTRL_AUTO_HALT_EN
                end else if (board_same) begin
                    state_d = HALT;
`endif
                end else begin
                    cnt_d   = reload_val;
                    state_d = RUN_WAIT;
                end
            end
            HALT: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        halted_d     = (state_d == HALT);
        load_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            run_mode_q      <= 1'b0;
            stop_pend_q     <= 1'b0;
            col_write_enb_q <= '0;
            col_val_q       <= '0;
            col_enable_q    <= 1'b0;
            gen_count_q     <= '0;
            extinct_q       <= 1'b0;
            stable_q        <= 1'b0;
            load_err_q      <= 1'b0;
            busy_q          <= 1'b0;
            halted_q        <= 1'b0;
            load_ready_q    <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            run_mode_q      <= run_mode_d;
            stop_pend_q     <= stop_pend_d;
            col_write_enb_q <= col_write_enb_d;
            col_val_q       <= col_val_d;
            col_enable_q    <= col_enable_d;
            gen_count_q     <= gen_count_d;
            extinct_q       <= extinct_d;
            stable_q        <= stable_d;
            load_err_q      <= load_err_d;
            busy_q          <= busy_d;
            halted_q        <= halted_d;
            load_ready_q    <= load_ready_d;
        end
    end

    assign col_write_enb = col_write_enb_q;
    assign col_val       = col_val_q;
    assign col_enable    = col_enable_q;
    assign gen_count     = gen_count_q;
    assign extinct       = extinct_q;
    assign stable        = stable_q;
    assign load_err      = load_err_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign load_ready    = load_ready_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Purpose: self-checking bench for life_gen_ctrl with a five-column, four-row array.
// Latency: expected strobes/pulses are queued with their due cycle when stimulus is driven.
// Backpressure: loads are only driven while the controller sits in IDLE.
module tb_life_gen_ctrl;

    localparam int NC   = 5;
    localparam int R    = 4;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_valid;
    logic            load_ready;
    logic [IDXW-1:0] load_col_idx;
    logic [R-1:0]    load_val;
    logic            cmd_run, cmd_step, cmd_stop;
    logic [15:0]     gen_period;
    logic [NC-1:0]   col_write_enb;
    logic [R-1:0]    col_val;
    logic            col_enable;
    logic [NC*R-1:0] alive_flat, alive_prev_flat;
    logic            busy, halted;
    logic [15:0]     gen_count;
    logic            extinct, stable, load_err;

    life_gen_ctrl #(.NUM_COLS(NC), .ROWS(R), .DIV_W(16)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_col_idx(load_col_idx), .load_val(load_val),
        .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
        .gen_period(gen_period),
        .col_write_enb(col_write_enb), .col_val(col_val), .col_enable(col_enable),
        .alive_flat(alive_flat), .alive_prev_flat(alive_prev_flat),
        .busy(busy), .halted(halted), .gen_count(gen_count),
        .extinct(extinct), .stable(stable), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct { int cyc; logic [15:0] gc; } en_exp_t;
    typedef struct { int cyc; logic [NC-1:0] enb; logic [R-1:0] val; } wr_exp_t;
    en_exp_t en_q[$];
    wr_exp_t wr_q[$];
    logic [15:0] exp_gc = '0;

    task automatic push_en(input int c);
        en_exp_t e;
        exp_gc = exp_gc + 16'd1;
        e.cyc  = c;
        e.gc   = exp_gc;
        en_q.push_back(e);
    endtask

    // Output monitor: every strobe and enable pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (col_write_enb != '0) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", wr_q.size(), 1);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    chk("wr_cycle", cyc, w.cyc);
                    chk("wr_enb", col_write_enb, w.enb);
                    chk("wr_val", col_val, w.val);
                end
            end
            if (col_enable) begin
                if (en_q.size() == 0) begin
                    chk("en_unexpected", en_q.size(), 1);
                end else begin
                    en_exp_t e;
                    e = en_q.pop_front();
                    chk("en_cycle", cyc, e.cyc);
                    chk("en_gen_count", gen_count, e.gc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_load(input logic [IDXW-1:0] idx, input logic [R-1:0] val);
        wr_exp_t w;
        int k;
        k = cyc;
        load_valid = 1'b1;
        load_col_idx = idx;
        load_val = val;
        if (int'(idx) < NC) begin
            w.cyc = k + 1;
            w.enb = NC'(1) << idx;
            w.val = val;
            wr_q.push_back(w);
        end
        exp_gc = '0;
        tick();
        load_valid = 1'b0;
        chk("ready_in_write", load_ready, 0);
        chk("busy_in_write", busy, 1);
        tick();
        chk("ready_after_write", load_ready, 1);
        chk("gc_cleared_by_load", gen_count, 0);
    endtask

    task automatic pulse_run();
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
    endtask

    int k;

    initial begin
        reset = 1'b1;
        load_valid = 1'b0; load_col_idx = '0; load_val = '0;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
        gen_period = 16'd3;
        alive_flat = '0; alive_prev_flat = '0;
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_write_enb", col_write_enb, 0);
        chk("rst_col_val", col_val, 0);
        chk("rst_enable", col_enable, 0);
        chk("rst_gen_count", gen_count, 0);
        chk("rst_flags", {extinct, stable, load_err, halted}, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_busy", busy, 0);

        // Pattern loads, including an out-of-range index
        do_load(3'd2, 4'hF);
        chk("load_err_clear", load_err, 0);
        do_load(3'd0, 4'hA);
        do_load(3'd5, 4'h9);
        chk("load_err_set", load_err, 1);
        do_load(3'd4, 4'h6);
        chk("load_err_sticky", load_err, 1);

        // Free run with period 3 on an oscillating board, stopped in RUN_WAIT
        alive_flat = 20'h000F0; alive_prev_flat = 20'h00F00;
        gen_period = 16'd3;
        k = cyc;
        push_en(k + 4); push_en(k + 9); push_en(k + 14);
        pulse_run();
        wait_to(k + 2);
        chk("run_busy", busy, 1);
        wait_to(k + 16);
        pulse_stop();
        chk("run_stop_idle", busy, 0);
        chk("run_gen_count", gen_count, exp_gc);
        chk("run_stable", stable, 0);
        chk("run_extinct", extinct, 0);

        // Load wins over run when both arrive in IDLE
        k = cyc;
        begin
            wr_exp_t w;
            w.cyc = k + 1; w.enb = 5'b00010; w.val = 4'h3;
            wr_q.push_back(w);
        end
        exp_gc = '0;
        load_valid = 1'b1; load_col_idx = 3'd1; load_val = 4'h3; cmd_run = 1'b1;
        tick();
        load_valid = 1'b0; cmd_run = 1'b0;
        tick();
        chk("prio_not_running", busy, 0);
        chk("prio_gc_cleared", gen_count, 0);

        // Single step on a dead board
        alive_flat = '0; alive_prev_flat = '0;
        k = cyc;
        push_en(k + 1);
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        wait_to(k + 3);
        chk("step_idle", busy, 0);
        chk("step_gen_count", gen_count, exp_gc);
        chk("step_extinct", extinct, 1);
        chk("step_stable", stable, 1);

        // Run with period 0 on a dead board: extinct halts; stop beats run in HALT
        gen_period = 16'd0;
        k = cyc;
        push_en(k + 2);
        pulse_run();
        chk("run_clears_extinct", extinct, 0);
        wait_to(k + 4);
        chk("extinct_halted", halted, 1);
        chk("extinct_flag", extinct, 1);
        cmd_run = 1'b1; cmd_stop = 1'b1;
        tick();
        cmd_run = 1'b0; cmd_stop = 1'b0;
        chk("halt_stop_wins", busy, 0);
        tick();
        chk("halt_stop_idle", {busy, halted}, 0);

        // Still-life board under free run
        alive_flat = 20'h00660; alive_prev_flat = 20'h00660;
        gen_period = 16'd2;
        k = cyc;
        push_en(k + 3);
`ifndef LIFE_CTRL_AUTO_HALT_EN
        push_en(k + 7);
`endif
        pulse_run();
        wait_to(k + 2);
        chk("still_stable_cleared", stable, 0);
        wait_to(k + 9);
        chk("still_stable", stable, 1);
`ifdef LIFE_CTRL_AUTO_HALT_EN
        chk("still_halted", halted, 1);
`else
        chk("still_running", {busy, halted}, 2'b10);
`endif
        pulse_stop();
        chk("still_stop_idle", busy, 0);
        chk("still_gen_count", gen_count, exp_gc);

        // Stop during the TICK cycle: pulse completes and counts
        alive_flat = 20'h000F0; alive_prev_flat = 20'h00F00;
        k = cyc;
        push_en(k + 3);
        pulse_run();
        wait_to(k + 3);
        pulse_stop();
        chk("tickstop_settle_busy", busy, 1);
        tick();
        chk("tickstop_idle", busy, 0);
        chk("tickstop_gen_count", gen_count, exp_gc);

        // Reset in the middle of a run
        gen_period = 16'd5;
        k = cyc;
        pulse_run();
        wait_to(k + 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_gc = '0;
        chk("midrst_gen_count", gen_count, 0);
        chk("midrst_state", {busy, halted, load_ready}, 3'b001);
        chk("midrst_flags", {extinct, stable, load_err}, 0);
        repeat (10) tick();
        chk("midrst_still_idle", busy, 0);

        chk("en_q_drained", en_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
